// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants and types for the EX stage (EX_MULT_EN adds the multiplier codes' use)
package ex_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;
    localparam logic [3:0] ALU_NOP = 4'd6;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - iterative shift-add multiplier, one step per cycle (used only with EX_MULT_EN)
module mult_seq
    import ex_pkg::*;
#(
    parameter int DW   = 32,
    parameter int MULW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);

    mult_state_e     state_q, state_d;
    logic [MULW-1:0] count_q, count_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;

    // Low DW bits of a two's-complement product equal the unsigned product's low bits.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        if (flush) begin
            state_d = MS_IDLE;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = MS_BUSY;
                    end
                end
                MS_BUSY: begin
                    if (a_q[0]) begin
                        acc_d = acc_q + b_q;
                    end
                    a_d     = a_q >> 1;
                    b_d     = b_q << 1;
                    count_d = count_q + 1'b1;
                    if (count_q == MULW'(DW - 1)) begin
                        state_d = MS_DONE;
                    end
                end
                MS_DONE: state_d = MS_IDLE;
                default: state_d = MS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign busy    = (state_q == MS_BUSY);
    assign done    = (state_q == MS_DONE);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS EX stage: ALU control, ALU, branch adder, EX/MEM register; EX_MULT_EN adds mult_seq
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int MULW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [1:0]    wb_ctl,
    input  logic [2:0]    m_ctl,
    input  logic          regdst,
    input  logic          alusrc,
    input  logic [1:0]    aluop,
    input  logic [DW-1:0] npc,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    input  logic [DW-1:0] s_extendout,
    input  logic [RW-1:0] instr_2016,
    input  logic [RW-1:0] instr_1511,
    output logic          stall,
    output logic [1:0]    wb_ctlout,
    output logic          branch,
    output logic          memread,
    output logic          memwrite,
    output logic          zero,
    output logic [DW-1:0] add_result,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] rdata2out,
    output logic [RW-1:0] five_bit_muxout
);

    logic [3:0]    alu_ctl;
    logic [DW-1:0] alu_b, alu_res;

    always_comb begin
        alu_ctl = ALU_ADD;
        case (aluop)
            ALUOP_ADD:  alu_ctl = ALU_ADD;
            ALUOP_SUB:  alu_ctl = ALU_SUB;
            ALUOP_ADD2: alu_ctl = ALU_ADD;
            default: begin
                case (s_extendout[5:0])
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
`ifdef EX_MULT_EN
                    FUNCT_MUL: alu_ctl = ALU_MUL;
`endif
                    default:   alu_ctl = ALU_NOP;
                endcase
            end
        endcase
    end

    assign alu_b = alusrc ? s_extendout : rdata2;

`ifdef EX_MULT_EN
    logic          is_mult, mult_busy, mult_done;
    logic [DW-1:0] mult_product;

    assign is_mult = (alu_ctl == ALU_MUL);

    mult_seq #(.DW(DW), .MULW(MULW)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (is_mult),
        .a       (rdata1),
        .b       (alu_b),
        .flush   (flush),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    // Stalls from the cycle the multiply enters EX until the product is ready.
    assign stall = is_mult & (mult_busy | ~mult_done);
`else
    logic [MULW-1:0] unused_mulw;
    assign unused_mulw = '0;
    assign stall       = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            ALU_ADD: alu_res = rdata1 + alu_b;
            ALU_SUB: alu_res = rdata1 - alu_b;
            ALU_AND: alu_res = rdata1 & alu_b;
            ALU_OR:  alu_res = rdata1 | alu_b;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(rdata1) < $signed(alu_b))};
`ifdef EX_MULT_EN
            ALU_MUL: alu_res = mult_product;
`endif
            default: alu_res = '0;
        endcase
    end

    logic [1:0]    wb_q, wb_d;
    logic [2:0]    m_q, m_d;
    logic          zero_q, zero_d;
    logic [DW-1:0] add_q, add_d, alu_q, alu_d, rd2_q, rd2_d;
    logic [RW-1:0] mux_q, mux_d;
    logic          load_data, load_ctl;

    // Flush wins: it kills controls but data still advances; a stall bubbles controls and holds data.
    assign load_data = flush | ~stall;
    assign load_ctl  = ~flush & ~stall;

    always_comb begin
        wb_d   = load_ctl ? wb_ctl : 2'b00;
        m_d    = load_ctl ? m_ctl : 3'b000;
        zero_d = zero_q;
        add_d  = add_q;
        alu_d  = alu_q;
        rd2_d  = rd2_q;
        mux_d  = mux_q;
        if (load_data) begin
            zero_d = (alu_res == '0);
            add_d  = npc + (s_extendout << 2);
            alu_d  = alu_res;
            rd2_d  = rdata2;
            mux_d  = regdst ? instr_1511 : instr_2016;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q   <= '0;
            m_q    <= '0;
            zero_q <= 1'b0;
            add_q  <= '0;
            alu_q  <= '0;
            rd2_q  <= '0;
            mux_q  <= '0;
        end else begin
            wb_q   <= wb_d;
            m_q    <= m_d;
            zero_q <= zero_d;
            add_q  <= add_d;
            alu_q  <= alu_d;
            rd2_q  <= rd2_d;
            mux_q  <= mux_d;
        end
    end

    assign wb_ctlout       = wb_q;
    assign branch          = m_q[2];
    assign memread         = m_q[1];
    assign memwrite        = m_q[0];
    assign zero            = zero_q;
    assign add_result      = add_q;
    assign alu_result      = alu_q;
    assign rdata2out       = rd2_q;
    assign five_bit_muxout = mux_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int MULW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    wb_ctl = '0;
    logic [2:0]    m_ctl = '0;
    logic          regdst = 1'b0, alusrc = 1'b0;
    logic [1:0]    aluop = '0;
    logic [DW-1:0] npc = '0, rdata1 = '0, rdata2 = '0, s_extendout = '0;
    logic [RW-1:0] instr_2016 = '0, instr_1511 = '0;
    logic          stall;
    logic [1:0]    wb_ctlout;
    logic          branch, memread, memwrite, zero;
    logic [DW-1:0] add_result, alu_result, rdata2out;
    logic [RW-1:0] five_bit_muxout;

    ex_stage #(.DW(DW), .RW(RW), .MULW(MULW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc),
        .rdata1(rdata1), .rdata2(rdata2), .s_extendout(s_extendout),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .stall(stall),
        .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
        .zero(zero), .add_result(add_result), .alu_result(alu_result),
        .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]    exp_wb;
    logic [2:0]    exp_m;
    logic          exp_zero;
    logic [DW-1:0] exp_add, exp_alu, exp_rd2;
    logic [RW-1:0] exp_mux;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (fn)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef EX_MULT_EN
            6'h18: return a * b;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic predict(input logic f);
        logic [DW-1:0] b;
        b        = alusrc ? s_extendout : rdata2;
        exp_wb   = f ? 2'b00 : wb_ctl;
        exp_m    = f ? 3'b000 : m_ctl;
        exp_alu  = ref_alu(aluop, s_extendout[5:0], rdata1, b);
        exp_zero = (exp_alu == 0);
        exp_add  = npc + s_extendout * 4;
        exp_rd2  = rdata2;
        exp_mux  = regdst ? instr_1511 : instr_2016;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        check("wb_ctlout", wb_ctlout, exp_wb);
        check("m_ctl", {branch, memread, memwrite}, exp_m);
        check("alu_result", alu_result, exp_alu);
        check("zero", zero, exp_zero);
        check("add_result", add_result, exp_add);
        check("rdata2out", rdata2out, exp_rd2);
        check("muxout", five_bit_muxout, exp_mux);
    endtask

    task automatic apply(input logic f);
        check("no_stall", stall, 1'b0);
        flush = f;
        predict(f);
        step();
        flush = 1'b0;
        check_all();
    endtask

    task automatic check_reset_zero();
        check("rst_stall", stall, 1'b0);
        check("rst_outs", {wb_ctlout, branch, memread, memwrite, zero}, 0);
        check("rst_add", add_result, 0);
        check("rst_alu", alu_result, 0);
        check("rst_rd2", rdata2out, 0);
        check("rst_mux", five_bit_muxout, 0);
    endtask

    task automatic set_rtype(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        aluop = 2'b10; alusrc = 1'b0; s_extendout = {26'd0, fn};
        rdata1 = a; rdata2 = b; regdst = 1'b1; instr_1511 = 5'd7; instr_2016 = 5'd2;
        wb_ctl = 2'b10; m_ctl = 3'b000;
    endtask

`ifdef EX_MULT_EN
    task automatic run_mult(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] prod);
        int n;
        set_rtype(6'h18, a, b);
        #1;
        n = 0;
        while (stall && n < 100) begin
            step();
            n++;
            check("mult_bubble", {wb_ctlout, branch, memread, memwrite}, 0);
        end
        check("mult_stall_cycles", n, DW + 1);
        step();
        check("mult_product", alu_result, prod);
        check("mult_wb", wb_ctlout, 2'b10);
        set_rtype(6'h20, 1, 1);
    endtask
`endif

    initial begin
        logic [5:0] fl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        #1;
        check_reset_zero();
        #11 rst_n = 1'b1;
        step();

        set_rtype(6'h20, 5, 7); instr_1511 = 5'd3;
        apply(1'b0);
        check("add_12", alu_result, 12);
        check("add_zero", zero, 0);
        check("add_mux", five_bit_muxout, 3);

        aluop = 2'b01; rdata1 = 9; rdata2 = 9; npc = 32'h100; s_extendout = 4;
        alusrc = 1'b0; m_ctl = 3'b100;
        apply(1'b0);
        check("beq_zero", zero, 1);
        check("beq_target", add_result, 32'h110);
        check("beq_branch", branch, 1);

        set_rtype(6'h2A, 32'hFFFF_FFFF, 1);
        apply(1'b0);
        check("slt_neg", alu_result, 1);

        aluop = 2'b00; alusrc = 1'b1; s_extendout = 32'hFFFF_FFFC; rdata1 = 32'h10;
        apply(1'b0);
        check("itype_add", alu_result, 32'hC);

        set_rtype(6'h3F, 3, 4);
        apply(1'b0);
        check("unknown_funct", alu_result, 0);
`ifndef EX_MULT_EN
        set_rtype(6'h18, 6, 7);
        apply(1'b0);
        check("mul_disabled", alu_result, 0);
`endif

        set_rtype(6'h20, 5, 7); wb_ctl = 2'b10; m_ctl = 3'b001;
        apply(1'b1);
        check("flush_regwrite", wb_ctlout, 0);
        check("flush_memwrite", memwrite, 0);
        check("flush_data", alu_result, 12);

        for (int i = 0; i < 200; i++) begin
            aluop = 2'($urandom); alusrc = 1'($urandom); regdst = 1'($urandom);
            wb_ctl = 2'($urandom); m_ctl = 3'($urandom);
            npc = $urandom; rdata1 = $urandom; rdata2 = $urandom; s_extendout = $urandom;
            instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
            if ($urandom_range(3) != 0) s_extendout[5:0] = fl[$urandom_range(4)];
            if ($urandom_range(7) == 0) rdata2 = rdata1;
`ifdef EX_MULT_EN
            if (s_extendout[5:0] == 6'h18) s_extendout[5:0] = 6'h20;
`endif
            apply(($urandom_range(7) == 0) ? 1'b1 : 1'b0);
        end

`ifdef EX_MULT_EN
        run_mult(6, 7, 42);
        set_rtype(6'h18, 6, 7);
        #1;
        check("mult_stall_start", stall, 1);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_rtype(6'h20, 1, 2);
        check("flush_mult_wb", wb_ctlout, 0);
        #1;
        check("flush_mult_stall", stall, 0);
        run_mult(-3, 5, 32'hFFFF_FFF1);
`endif

        set_rtype(6'h20, 5, 7);
        apply(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_zero();
        #3 rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
